mtm_alu_host: RTL and testbench
===============================

# mtm_alu_host

Host-side serial master for the mtm_Alu serial link. It accepts one operation (A, B, op) on a valid/ready request port and serializes it onto `sin` as 9 frames with CRC4. It then deserializes the ALU's answer from `sout`, checks the frame format and CRC3, and presents C, the flags and a status code on a one-cycle response strobe. It is the synthesizable counterpart of the ALU's input decoder and output encoder, and sits between a stimulus source and the DUT serial pins.

## Interface
- `TIMEOUT`, default 1023: maximum consecutive cycles spent waiting for any response start bit before the transaction is aborted.
- `clk` in 1: single clock; `sin` is driven and `sout` sampled on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_a`, `req_b` in 32: operands.
- `req_op` in 3: opcode (AND 000, OR 001, ADD 100, SUB 101; other codes are sent unchanged).
- `sin` out 1: serial line to the ALU; idles high.
- `sout` in 1: serial line from the ALU; idles high.
- `rsp_valid` out 1: one-cycle strobe when the response fields are valid.
- `rsp_c` out 32: result.
- `rsp_flags` out 4: {Carry, Overflow, Zero, Negative}.
- `rsp_err_flags` out 6: payload bits [6:1] of an ALU error frame; 0 otherwise.
- `rsp_status` out 2: 00 OK, 01 ALU error frame, 10 timeout, 11 framing or CRC error.

## Operation
- **Frame format:** 11 bits, MSB first: start 0, type (0 = data, 1 = ctl), payload[7:0] MSB first, stop 1.
- **Request frames:**
  - Frames 0–3 carry B bytes [31:24] down to [7:0].
  - Frames 4–7 carry A bytes [31:24] down to [7:0].
  - Frame 8 is a ctl frame with payload {0, op[2:0], crc4[3:0]}.
- **CRC4:** polynomial x^4+x+1, initial value 0, computed over the 68-bit vector {B, A, 1'b1, op}, MSB first.
- **Frame spacing:** request frames are sent back-to-back with no idle bits.
- **States:**
  - IDLE: `req_ready`=1, `sin`=1. On handshake, latch the operands, compute CRC4 and go to TX.
  - TX: bit counter 0–10 and frame counter 0–8. After the stop bit of frame 8, go to RX_WAIT.
  - RX_WAIT: `sin`=1. The timeout counter clears on entry and increments each cycle `sout`=1. On `sout`=0, go to RX_FRAME. When the counter reaches TIMEOUT, set status 10 and go to DONE.
  - RX_FRAME: shift 10 more bits, then classify the frame (see below).
  - DONE: `rsp_valid`=1 for one cycle, then go to IDLE.
- **Response classification:**
  - Stop bit 0: status 11, go to DONE.
  - First frame has type=1: it is an error frame. `rsp_err_flags` = payload[6:1], status 01, go to DONE. The payload parity bit is not checked.
  - Data frames 0–3 fill C, MSB byte first.
  - A ctl frame before 4 data frames, or a data frame in position 4: status 11.
  - Frame 4 is ctl with payload {0, flags[3:0], crc3[2:0]}. Compute CRC3 (x^3+x+1, initial value 0) over {C, 1'b0, flags}. A mismatch or payload[7]=1 gives status 11; otherwise status 00.
  - After each non-final frame, return to RX_WAIT; the timeout counter restarts.
- **Response field hold:** `rsp_c`, `rsp_flags`, `rsp_err_flags` and `rsp_status` hold their value from DONE until the next DONE. On an error or timeout, the fields that were not received are 0.
- **TX behaviour:** `sout` is ignored during TX. `req_*` are ignored outside IDLE.

## Timing
- **Reset values:**
  - `sin`=1, `req_ready`=1, `rsp_valid`=0.
  - `rsp_c`, `rsp_flags`, `rsp_err_flags` and `rsp_status` = 0.
  - State = IDLE; all counters 0.
- **Request handshake:** occurs at edge N when `req_valid`&&`req_ready`.
- **Request serialization:** the start bit of frame 0 appears on `sin` after edge N. Bit k of the request is driven during cycle N+1+k, k=0..98. `sin` returns to 1 at N+100.
- **Response sampling:** `sout` is sampled once per cycle with no synchronizer; the same clock is shared with the DUT.
- **Response latency:** `rsp_valid` is high in the cycle after the final stop bit is sampled, or in the cycle after the timeout is reached. `req_ready` rises the following cycle, so back-to-back requests are separated by at least one idle cycle.
- **Timeout:** exactly TIMEOUT high cycles after entering RX_WAIT, `rsp_valid` asserts on the next cycle.
- **Reset mid-operation:** `rst` asynchronously forces `sin`=1 and IDLE. No `rsp_valid` is generated for the aborted transaction.

## Test plan
- ADD, A=1, B=2, with a correct DUT -> `sin` carries 99 bits with CRC4 matching the model; `rsp_c`=0x00000003, `rsp_flags`=0000, `rsp_status`=00.
- AND, A=0xFFFF0000, B=0x0000FFFF -> `rsp_c`=0, Zero flag=1, status 00.
- SUB, B=0x80000000, A=1 -> `rsp_c`=0x7FFFFFFF, Overflow=1, status 00.
- Op 3'b010 -> the DUT returns an error frame; status 01 and `rsp_err_flags` equal the error-frame payload bits.
- Bench flips one bit of C on `sout` -> status 11. A bench holding `sout` high with TIMEOUT=16 -> `rsp_valid` 17 cycles after the last TX stop bit, status 10.
- Assert `rst` during frame 3 of TX -> `sin`=1 in the same cycle. No `rsp_valid` occurs, and a new request completes normally after release.

Source files
------------

// File: rtl/mtm_alu_host.sv
`default_nettype none
// ============================================================================
//  Module      : mtm_alu_host
//  Description : Host-side serial master for the mtm_Alu link. Serialises one
//                (A, B, op) request as nine 11-bit frames with CRC4 onto sin,
//                then deserialises and checks the ALU answer from sout and
//                reports C, flags and a status code on a one-cycle strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtm_alu_host #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        sin,
    input  logic        sout,
    output logic        rsp_valid,
    output logic [31:0] rsp_c,
    output logic [3:0]  rsp_flags,
    output logic [5:0]  rsp_err_flags,
    output logic [1:0]  rsp_status
);

    localparam int c_to_width = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_to_width-1:0] c_to_last = c_to_width'(TIMEOUT - 1);

    localparam logic [1:0] c_st_ok      = 2'b00;
    localparam logic [1:0] c_st_alu_err = 2'b01;
    localparam logic [1:0] c_st_timeout = 2'b10;
    localparam logic [1:0] c_st_frame   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX       = 3'd1,
        S_RX_WAIT  = 3'd2,
        S_RX_FRAME = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [31:0]           r_a;
    logic [31:0]           r_b;
    logic [2:0]            r_op;
    logic [3:0]            r_crc4;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            r_frame_cnt;
    logic [c_to_width-1:0] r_to_cnt;
    logic [8:0]            r_rx_shift;
    logic [31:0]           r_c_acc;

    logic [7:0]  w_tx_payload;
    logic        w_tx_type;
    logic [10:0] w_tx_frame;
    logic [3:0]  w_tx_idx;
    logic        w_rx_type;
    logic [7:0]  w_rx_payload;
    logic [2:0]  w_rx_crc3;
    logic        w_done;
    logic        w_store_byte;
    logic [31:0] w_c_n;
    logic [1:0]  w_status_n;
    logic [3:0]  w_flags_n;
    logic [5:0]  w_err_n;

    // CRC4, polynomial x^4+x+1, zero seed, MSB first
    function automatic logic [3:0] f_crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    // CRC3, polynomial x^3+x+1, zero seed, MSB first
    function automatic logic [2:0] f_crc3(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'h0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
        end
        return c;
    endfunction

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);

    // Select the frame being transmitted: four B bytes, four A bytes, one ctl frame
    always_comb begin
        w_tx_payload = 8'h00;
        w_tx_type    = 1'b0;
        case (r_frame_cnt)
            4'd0:    w_tx_payload = r_b[31:24];
            4'd1:    w_tx_payload = r_b[23:16];
            4'd2:    w_tx_payload = r_b[15:8];
            4'd3:    w_tx_payload = r_b[7:0];
            4'd4:    w_tx_payload = r_a[31:24];
            4'd5:    w_tx_payload = r_a[23:16];
            4'd6:    w_tx_payload = r_a[15:8];
            4'd7:    w_tx_payload = r_a[7:0];
            4'd8: begin
                w_tx_payload = {1'b0, r_op, r_crc4};
                w_tx_type    = 1'b1;
            end
            default: w_tx_payload = 8'h00;
        endcase
    end

    assign w_tx_frame = {1'b0, w_tx_type, w_tx_payload, 1'b1};
    assign w_tx_idx   = 4'd10 - r_bit_cnt;

    // Line is decoded from state so an asynchronous reset returns it high at once
    assign sin = (r_state == S_TX) ? w_tx_frame[w_tx_idx] : 1'b1;

    // Type and payload of the frame being received; sout carries its stop bit
    // in the last RX_FRAME cycle
    assign w_rx_type    = r_rx_shift[8];
    assign w_rx_payload = r_rx_shift[7:0];
    assign w_rx_crc3    = f_crc3({r_c_acc, 1'b0, w_rx_payload[6:3]});

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic and response classification
    always_comb begin
        w_state_n    = r_state;
        w_done       = 1'b0;
        w_store_byte = 1'b0;
        w_c_n        = r_c_acc;
        w_status_n   = c_st_ok;
        w_flags_n    = 4'h0;
        w_err_n      = 6'h00;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_n = S_TX;
                end
            end
            S_TX: begin
                if ((r_frame_cnt == 4'd8) && (r_bit_cnt == 4'd10)) begin
                    w_state_n = S_RX_WAIT;
                end
            end
            S_RX_WAIT: begin
                if (!sout) begin
                    w_state_n = S_RX_FRAME;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_n  = S_DONE;
                    w_done     = 1'b1;
                    w_status_n = c_st_timeout;
                end
            end
            S_RX_FRAME: begin
                if (r_bit_cnt == 4'd9) begin
                    if (!sout) begin
                        // Missing stop bit
                        w_state_n  = S_DONE;
                        w_done     = 1'b1;
                        w_status_n = c_st_frame;
                    end else if ((r_frame_cnt == 4'd0) && w_rx_type) begin
                        // ALU error frame; parity bit deliberately not checked
                        w_state_n  = S_DONE;
                        w_done     = 1'b1;
                        w_status_n = c_st_alu_err;
                        w_err_n    = w_rx_payload[6:1];
                    end else if (!w_rx_type) begin
                        if (r_frame_cnt == 4'd4) begin
                            // Fifth data frame where the ctl frame belongs
                            w_state_n  = S_DONE;
                            w_done     = 1'b1;
                            w_status_n = c_st_frame;
                        end else begin
                            w_state_n    = S_RX_WAIT;
                            w_store_byte = 1'b1;
                            case (r_frame_cnt[1:0])
                                2'd0:    w_c_n[31:24] = w_rx_payload;
                                2'd1:    w_c_n[23:16] = w_rx_payload;
                                2'd2:    w_c_n[15:8]  = w_rx_payload;
                                default: w_c_n[7:0]   = w_rx_payload;
                            endcase
                        end
                    end else if (r_frame_cnt != 4'd4) begin
                        // Ctl frame arrived before all four C bytes
                        w_state_n  = S_DONE;
                        w_done     = 1'b1;
                        w_status_n = c_st_frame;
                    end else begin
                        w_state_n  = S_DONE;
                        w_done     = 1'b1;
                        w_flags_n  = w_rx_payload[6:3];
                        w_status_n = (w_rx_payload[7] || (w_rx_crc3 != w_rx_payload[2:0]))
                                     ? c_st_frame : c_st_ok;
                    end
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Datapath: request latch, bit/frame/timeout counters, receive shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= 32'h0;
            r_b         <= 32'h0;
            r_op        <= 3'h0;
            r_crc4      <= 4'h0;
            r_bit_cnt   <= 4'h0;
            r_frame_cnt <= 4'h0;
            r_to_cnt    <= '0;
            r_rx_shift  <= 9'h0;
            r_c_acc     <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt   <= 4'h0;
                    r_frame_cnt <= 4'h0;
                    r_to_cnt    <= '0;
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_op    <= req_op;
                        r_crc4  <= f_crc4({req_b, req_a, 1'b1, req_op});
                        r_c_acc <= 32'h0;
                    end
                end
                S_TX: begin
                    r_to_cnt <= '0;
                    if (r_bit_cnt == 4'd10) begin
                        r_bit_cnt   <= 4'h0;
                        // Frame counter is reused to index the response frames
                        r_frame_cnt <= (r_frame_cnt == 4'd8) ? 4'h0 : r_frame_cnt + 4'd1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                S_RX_WAIT: begin
                    r_bit_cnt <= 4'h0;
                    if (sout) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_RX_FRAME: begin
                    r_to_cnt   <= '0;
                    r_rx_shift <= {r_rx_shift[7:0], sout};
                    if (r_bit_cnt == 4'd9) begin
                        r_bit_cnt <= 4'h0;
                        if (w_store_byte) begin
                            r_c_acc     <= w_c_n;
                            r_frame_cnt <= r_frame_cnt + 4'd1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                default: begin
                    r_bit_cnt <= 4'h0;
                end
            endcase
        end
    end

    // Response fields load on entry to DONE and hold until the next DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_c         <= 32'h0;
            rsp_flags     <= 4'h0;
            rsp_err_flags <= 6'h00;
            rsp_status    <= 2'b00;
        end else if (w_done) begin
            rsp_c         <= r_c_acc;
            rsp_flags     <= w_flags_n;
            rsp_err_flags <= w_err_n;
            rsp_status    <= w_status_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mtm_alu_host
//  Description : Self-checking bench for mtm_alu_host. The bench plays the
//                ALU on the serial pins and predicts every response from a
//                behavioural model (polynomial division CRCs, 33-bit ALU).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_host;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic        sin;
    logic        sout;
    logic        rsp_valid;
    logic [31:0] rsp_c;
    logic [3:0]  rsp_flags;
    logic [5:0]  rsp_err_flags;
    logic [1:0]  rsp_status;

    typedef struct packed {
        logic [31:0] c;
        logic [3:0]  flags;
        logic [5:0]  err;
        logic [1:0]  status;
    } rsp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    rsp_t exp_q[$];

    mtm_alu_host #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .sin          (sin),
        .sout         (sout),
        .rsp_valid    (rsp_valid),
        .rsp_c        (rsp_c),
        .rsp_flags    (rsp_flags),
        .rsp_err_flags(rsp_err_flags),
        .rsp_status   (rsp_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC as remainder of message*x^4 divided by x^4+x+1
    function automatic logic [3:0] m_crc4(input logic [31:0] b, input logic [31:0] a,
                                          input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    // CRC as remainder of message*x^3 divided by x^3+x+1
    function automatic logic [2:0] m_crc3(input logic [31:0] c, input logic [3:0] fl);
        logic [39:0] r;
        r = {c, 1'b0, fl, 3'b000};
        for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic logic [10:0] mk_frame(input logic typ, input logic [7:0] pl);
        return {1'b0, typ, pl, 1'b1};
    endfunction

    // ALU behaviour: SUB is B-A, carry is bit 32 of the 33-bit result
    task automatic m_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         output logic [31:0] c, output logic [3:0] fl, output logic bad);
        logic [32:0] w;
        logic        cy;
        logic        ov;
        bad = 1'b0; cy = 1'b0; ov = 1'b0; c = 32'h0;
        case (op)
            3'b000: c = a & b;
            3'b001: c = a | b;
            3'b100: begin
                w = {1'b0, a} + {1'b0, b}; c = w[31:0]; cy = w[32];
                ov = (a[31] == b[31]) && (c[31] != a[31]);
            end
            3'b101: begin
                w = {1'b0, b} - {1'b0, a}; c = w[31:0]; cy = w[32];
                ov = (a[31] != b[31]) && (c[31] != b[31]);
            end
            default: bad = 1'b1;
        endcase
        fl = {cy, ov, (c == 32'h0), c[31]};
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] pl);
        logic [10:0] fr;
        fr = mk_frame(typ, pl);
        for (int j = 10; j >= 0; j--) begin
            @(negedge clk);
            sout = fr[j];
        end
    endtask

    task automatic idle_line(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            sout = 1'b1;
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", req_ready, 1'b1);
    endtask

    // mode: 0 normal, 1 flip one C bit, 2 no answer (timeout), 3 ctl after two bytes
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input int mode, output rsp_t got, output logic [10:0] f8);
        logic [98:0] expv;
        logic [98:0] gotv;
        logic [31:0] c;
        logic [31:0] csent;
        logic [3:0]  fl;
        logic        bad;
        rsp_t        e;
        int          early;
        int          nd;
        int          fidx;
        m_alu(a, b, op, c, fl, bad);
        for (int f = 0; f < 4; f++) begin
            expv[98 - 11*f -: 11]      = mk_frame(1'b0, b[31 - 8*f -: 8]);
            expv[98 - 11*(f+4) -: 11]  = mk_frame(1'b0, a[31 - 8*f -: 8]);
        end
        expv[10:0] = mk_frame(1'b1, {1'b0, op, m_crc4(b, a, op)});

        wait_ready();
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        @(posedge clk);
        for (int k = 0; k < 99; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
            end
            gotv[98 - k] = sin;
        end
        for (int f = 0; f < 9; f++)
            check($sformatf("sin_frame%0d", f), gotv[98 - 11*f -: 11], expv[98 - 11*f -: 11]);
        f8 = gotv[10:0];

        @(negedge clk);
        check("sin_idle_after_tx", sin, 1'b1);
        check("rsp_valid_during_rx", rsp_valid, 1'b0);

        if (mode == 2) begin
            e = '{c: 32'h0, flags: 4'h0, err: 6'h0, status: 2'b10};
            exp_q.push_back(e);
            early = 0;
            for (int i = 2; i <= TIMEOUT; i++) begin
                @(negedge clk);
                if (rsp_valid) early++;
            end
            check("timeout_early_valid", early, 0);
        end else if (bad) begin
            e = '{c: 32'h0, flags: 4'h0, err: 6'b001001, status: 2'b01};
            exp_q.push_back(e);
            idle_line($urandom_range(0, 3));
            send_frame(1'b1, {1'b1, 6'b001001, 1'b1});
        end else begin
            csent = c;
            if (mode == 1) begin
                fidx = $urandom_range(0, 31);
                csent[fidx] = ~csent[fidx];
            end
            nd = (mode == 3) ? 2 : 4;
            for (int i = 0; i < nd; i++) begin
                idle_line($urandom_range(0, 3));
                send_frame(1'b0, csent[31 - 8*i -: 8]);
            end
            if (mode == 0)      e = '{c: c, flags: fl, err: 6'h0, status: 2'b00};
            else if (mode == 1) e = '{c: csent, flags: fl, err: 6'h0, status: 2'b11};
            else                e = '{c: {c[31:16], 16'h0}, flags: 4'h0, err: 6'h0, status: 2'b11};
            exp_q.push_back(e);
            idle_line($urandom_range(0, 3));
            send_frame(1'b1, {1'b0, fl, m_crc3(c, fl)});
        end

        @(negedge clk);
        check("rsp_valid_latency", rsp_valid, 1'b1);
        check("req_ready_in_done", req_ready, 1'b0);
        got = '{c: rsp_c, flags: rsp_flags, err: rsp_err_flags, status: rsp_status};
        @(negedge clk);
        check("rsp_valid_one_cycle", rsp_valid, 1'b0);
        check("req_ready_after_done", req_ready, 1'b1);
    endtask

    task automatic reset_mid_tx();
        int seen;
        wait_ready();
        req_valid = 1'b1; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0; req_op = 3'b100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (33) @(negedge clk);
        check("sin_frame3_start", sin, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("sin_on_reset", sin, 1'b1);
        check("ready_on_reset", req_ready, 1'b1);
        check("rsp_valid_on_reset", rsp_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (130) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", seen, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Compare process: every strobe must match the next predicted response and
    // the fields must hold that value on every other cycle
    initial begin
        rsp_t last;
        rsp_t e;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = '0;
            end else begin
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_valid_unexpected", rsp_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        last = e;
                    end
                end
                check("rsp_fields", {rsp_c, rsp_flags, rsp_err_flags, rsp_status}, last);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t        got;
        logic [10:0] f8;
        logic [2:0]  ops [4];
        logic [2:0]  op;
        int          r;
        int          m;
        int          mode;
        ops = '{3'b000, 3'b001, 3'b100, 3'b101};
        rst = 1'b1; req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0; req_op = 3'h0; sout = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_sin", sin, 1'b1);
        check("reset_ready", req_ready, 1'b1);
        check("reset_valid", rsp_valid, 1'b0);
        check("reset_fields", {rsp_c, rsp_flags, rsp_err_flags, rsp_status}, 44'h0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(32'd1, 32'd2, 3'b100, 0, got, f8);
        check("add_ctl_frame", f8, 11'b0_1_01001100_1);
        check("add_c", got.c, 32'h0000_0003);
        check("add_flags", got.flags, 4'b0000);
        check("add_status", got.status, 2'b00);

        run_txn(32'hFFFF_0000, 32'h0000_FFFF, 3'b000, 0, got, f8);
        check("and_c", got.c, 32'h0);
        check("and_flags", got.flags, 4'b0010);
        check("and_status", got.status, 2'b00);

        run_txn(32'h0000_0001, 32'h8000_0000, 3'b101, 0, got, f8);
        check("sub_c", got.c, 32'h7FFF_FFFF);
        check("sub_flags", got.flags, 4'b0100);
        check("sub_status", got.status, 2'b00);

        run_txn(32'h0000_0005, 32'h0000_0007, 3'b010, 0, got, f8);
        check("badop_status", got.status, 2'b01);
        check("badop_err", got.err, 6'b001001);

        run_txn(32'h0102_0304, 32'h1111_2222, 3'b100, 1, got, f8);
        check("flip_status", got.status, 2'b11);

        run_txn(32'h0000_0010, 32'h0000_0020, 3'b001, 2, got, f8);
        check("timeout_status", got.status, 2'b10);
        check("timeout_c", got.c, 32'h0);

        run_txn(32'hA5A5_0000, 32'h0000_5A5A, 3'b001, 3, got, f8);
        check("early_ctl_status", got.status, 2'b11);
        check("early_ctl_c", got.c, 32'hA5A5_0000);

        reset_mid_tx();
        run_txn(32'd40, 32'd2, 3'b100, 0, got, f8);
        check("post_reset_c", got.c, 32'd42);
        check("post_reset_status", got.status, 2'b00);

        for (int t = 0; t < 30; t++) begin
            r    = $urandom_range(0, 9);
            op   = (r < 8) ? ops[r % 4] : 3'($urandom_range(0, 7));
            m    = $urandom_range(0, 9);
            mode = (m < 6) ? 0 : (m < 8) ? 1 : (m < 9) ? 2 : 3;
            run_txn(pick(), pick(), op, mode, got, f8);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
